// File: rtl/mam_sram_responder.sv
// -----------------------------------------------------------------------------
// mam_sram_responder
//
// Bridges a request/write-data/read-data handshake interface onto a
// single-port synchronous SRAM. Requests carry a byte address relative to
// BASE_ADDR and an optional burst length. Each request is turned into one SRAM
// access per beat at consecutive word addresses. Bursts wrap modulo the SRAM
// depth.
//
// Optional feature (macro MAM_SRAM_RANGE_CHECK_EN):
//    A request whose start byte address lies outside the SRAM window gets the
//    following treatment. Every beat of it completes its handshake normally,
//    but no SRAM strobe is issued. Reads return zero. The sticky err flag is
//    set and stays set until reset. Without the macro, err is tied low and the
//    address is simply truncated to the SRAM word-address width.
//
// Ports
//    clk, rst          : clock and asynchronous active-high reset
//    req_valid/ready   : request handshake (ready only while idle)
//    req_rw            : 0 read, 1 write
//    req_addr          : byte address of the first beat
//    req_burst         : 1 = burst of req_beats beats (0 treated as 1)
//    req_beats         : burst length
//    write_valid/ready : write beat handshake
//    write_data        : write beat data
//    write_strb        : byte enables (honoured for single-beat transfers)
//    read_valid/ready  : read beat handshake
//    read_data         : read beat data, held until accepted
//    sram_ce, sram_we  : SRAM strobe and write enable
//    sram_addr         : SRAM word address
//    sram_wdata        : SRAM write data
//    sram_be           : SRAM byte enables
//    sram_rdata        : SRAM read data, valid the cycle after a read strobe
//    err               : sticky out-of-range flag
// -----------------------------------------------------------------------------
module mam_sram_responder #(
   parameter int                    DATA_WIDTH     = 16,
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    MEM_ADDR_WIDTH = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = {ADDR_WIDTH{1'b0}}
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_rw,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic                      req_burst,
   input  logic [13:0]               req_beats,
   input  logic                      write_valid,
   input  logic [DATA_WIDTH-1:0]     write_data,
   input  logic [DATA_WIDTH/8-1:0]   write_strb,
   output logic                      write_ready,
   output logic                      read_valid,
   output logic [DATA_WIDTH-1:0]     read_data,
   input  logic                      read_ready,
   output logic                      sram_ce,
   output logic                      sram_we,
   output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0]     sram_wdata,
   output logic [DATA_WIDTH/8-1:0]   sram_be,
   input  logic [DATA_WIDTH-1:0]     sram_rdata,
   output logic                      err
);

   localparam int BYTES      = DATA_WIDTH / 8;
   localparam int SHIFT      = $clog2(BYTES);
   localparam int RANGE_BITS = MEM_ADDR_WIDTH + SHIFT;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WRITE      = 3'd1,
      READ_ISSUE = 3'd2,
      READ_WAIT  = 3'd3,
      READ_DATA  = 3'd4
   } state_t;

   state_t                    state_r, state_s;
   logic [13:0]               beats_r, beats_s;
   logic [MEM_ADDR_WIDTH-1:0] addr_r, addr_s;
   logic                      single_r, single_s;
   logic [DATA_WIDTH-1:0]     read_data_r, read_data_s;

   logic                      accept_s;
   logic                      beat_access_s;
   logic                      beat_oor_s;
   logic [ADDR_WIDTH-1:0]     req_offset_s;
   logic [ADDR_WIDTH-1:0]     req_word_s;
   logic [13:0]               req_len_s;
   logic                      unused_s;

   // Byte offset into the SRAM window and the resulting word index.
   assign req_offset_s  = req_addr - BASE_ADDR;
   assign req_word_s    = req_offset_s >> SHIFT;
   // Non-burst requests and zero-length bursts both move exactly one beat.
   assign req_len_s     = (!req_burst || (req_beats == 14'd0)) ? 14'd1 : req_beats;
   assign accept_s      = (state_r == IDLE) && req_valid;
   // Cycles in which a beat would touch the SRAM.
   assign beat_access_s = ((state_r == WRITE) && write_valid) || (state_r == READ_ISSUE);
   assign read_data     = read_data_r;

   // Bits of the offset beyond the SRAM window are dropped by design.
   assign unused_s = ^{req_offset_s, req_word_s, beat_access_s};

`ifdef MAM_SRAM_RANGE_CHECK_EN
   logic oor_r;
   logic err_r;
   logic req_oor_s;

   // Any offset bit above the window means the address is outside the SRAM.
   // The offset is unsigned, so addresses below BASE_ADDR wrap high and are
   // caught here as well. Later beats of an in-range burst wrap inside the
   // window and therefore stay in range.
   assign req_oor_s  = |(req_offset_s >> RANGE_BITS);
   assign beat_oor_s = oor_r;
   assign err        = err_r;

   // Out-of-range flag of the active request and the sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oor_r <= 1'b0;
         err_r <= 1'b0;
      end else begin
         if (accept_s) begin
            oor_r <= req_oor_s;
         end else begin
            oor_r <= oor_r;
         end
         if (beat_access_s && oor_r) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
      end
   end
`else
   assign beat_oor_s = 1'b0;
   assign err        = 1'b0;
`endif

   // Next-state logic and handshake/SRAM strobe outputs.
   always_comb begin
      state_s     = state_r;
      beats_s     = beats_r;
      addr_s      = addr_r;
      single_s    = single_r;
      read_data_s = read_data_r;
      req_ready   = 1'b0;
      write_ready = 1'b0;
      read_valid  = 1'b0;
      sram_ce     = 1'b0;
      sram_we     = 1'b0;
      sram_addr   = addr_r;
      sram_wdata  = write_data;
      sram_be     = {BYTES{1'b0}};
      case (state_r)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               beats_s  = req_len_s;
               single_s = (req_len_s == 14'd1);
               addr_s   = req_word_s[MEM_ADDR_WIDTH-1:0];
               state_s  = req_rw ? WRITE : READ_ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         WRITE: begin
            write_ready = 1'b1;
            if (write_valid) begin
               sram_ce = !beat_oor_s;
               sram_we = !beat_oor_s;
               // Byte strobes only make sense for a lone beat; bursts write whole words.
               sram_be = beat_oor_s ? {BYTES{1'b0}} :
                         (single_r ? write_strb : {BYTES{1'b1}});
               if (beats_r == 14'd1) begin
                  beats_s = 14'd0;
                  state_s = IDLE;
               end else begin
                  beats_s = beats_r - 14'd1;
                  addr_s  = addr_r + MEM_ADDR_WIDTH'(1);
               end
            end else begin
               state_s = WRITE;
            end
         end
         READ_ISSUE: begin
            sram_ce = !beat_oor_s;
            state_s = READ_WAIT;
         end
         READ_WAIT: begin
            read_data_s = beat_oor_s ? {DATA_WIDTH{1'b0}} : sram_rdata;
            state_s     = READ_DATA;
         end
         READ_DATA: begin
            read_valid = 1'b1;
            if (read_ready) begin
               if (beats_r == 14'd1) begin
                  beats_s = 14'd0;
                  state_s = IDLE;
               end else begin
                  beats_s = beats_r - 14'd1;
                  addr_s  = addr_r + MEM_ADDR_WIDTH'(1);
                  state_s = READ_ISSUE;
               end
            end else begin
               state_s = READ_DATA;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         beats_r     <= 14'd0;
         addr_r      <= {MEM_ADDR_WIDTH{1'b0}};
         single_r    <= 1'b0;
         read_data_r <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r     <= state_s;
         beats_r     <= beats_s;
         addr_r      <= addr_s;
         single_r    <= single_s;
         read_data_r <= read_data_s;
      end
   end

endmodule

// File: tb/tb_mam_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_mam_sram_responder
//
// Drives mam_sram_responder against a behavioural SRAM. A shadow memory holds
// the contents the SRAM should have. Writes are logged at the SRAM port and
// read data is checked against the shadow memory. Covered cases:
//    - directed single, burst, stalled, wrapping and reset-abort transfers
//    - randomized transfers
// -----------------------------------------------------------------------------
module tb_mam_sram_responder;

   localparam int              DW    = 16;
   localparam int              AW    = 32;
   localparam int              MW    = 6;
   localparam int              NB    = DW / 8;
   localparam int              DEPTH = 1 << MW;
   localparam logic [AW-1:0]   BASE  = 32'h0000_1000;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_rw;
   logic [AW-1:0] req_addr;
   logic          req_burst;
   logic [13:0]   req_beats;
   logic          write_valid;
   logic [DW-1:0] write_data;
   logic [NB-1:0] write_strb;
   logic          write_ready;
   logic          read_valid;
   logic [DW-1:0] read_data;
   logic          read_ready;
   logic          sram_ce;
   logic          sram_we;
   logic [MW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [NB-1:0] sram_be;
   logic [DW-1:0] sram_rdata;
   logic          err;

   int checks = 0;
   int errors = 0;

   mam_sram_responder #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .MEM_ADDR_WIDTH (MW),
      .BASE_ADDR      (BASE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_rw      (req_rw),
      .req_addr    (req_addr),
      .req_burst   (req_burst),
      .req_beats   (req_beats),
      .write_valid (write_valid),
      .write_data  (write_data),
      .write_strb  (write_strb),
      .write_ready (write_ready),
      .read_valid  (read_valid),
      .read_data   (read_data),
      .read_ready  (read_ready),
      .sram_ce     (sram_ce),
      .sram_we     (sram_we),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata),
      .sram_be     (sram_be),
      .sram_rdata  (sram_rdata),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural synchronous SRAM.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (sram_ce) begin
         if (sram_we) begin
            for (int k = 0; k < NB; k++) begin
               if (sram_be[k]) mem[sram_addr][k*8 +: 8] <= sram_wdata[k*8 +: 8];
            end
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   // Log of every SRAM strobe seen at a clock edge.
   int            strobe_n = 0;
   logic          log_we   [4096];
   logic [MW-1:0] log_addr [4096];
   logic [NB-1:0] log_be   [4096];
   logic [DW-1:0] log_wd   [4096];
   always @(posedge clk) begin
      if (sram_ce && strobe_n < 4096) begin
         log_we[strobe_n]   = sram_we;
         log_addr[strobe_n] = sram_addr;
         log_be[strobe_n]   = sram_be;
         log_wd[strobe_n]   = sram_wdata;
         strobe_n++;
      end
   end

   // Shadow memory: the contents the SRAM should have.
   logic [DW-1:0] ref_mem [DEPTH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int eff_len(input bit burst, input logic [13:0] beats);
      return (!burst || beats == 14'd0) ? 1 : int'(beats);
   endfunction

   function automatic int word_of(input logic [AW-1:0] a);
      logic [AW-1:0] off;
      off = a - BASE;
      return int'((off / NB) % DEPTH);
   endfunction

   task automatic do_write(input logic [AW-1:0] addr, input bit burst, input logic [13:0] beats,
                           input logic [NB-1:0] strb, input int max_gap,
                           input bit use_fixed, input logic [DW-1:0] fixed);
      int            n;
      int            w;
      int            start;
      int            gap;
      logic [DW-1:0] d [$];
      logic [DW-1:0] data;
      logic [NB-1:0] be_exp;
      n      = eff_len(burst, beats);
      w      = word_of(addr);
      be_exp = (n == 1) ? strb : {NB{1'b1}};
      start  = strobe_n;
      @(negedge clk);
      chk("wr_req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_rw = 1'b1; req_addr = addr; req_burst = burst; req_beats = beats;
      @(negedge clk);
      req_valid = 1'b0;
      for (int b = 0; b < n; b++) begin
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("wr_gap_ready", 32'(write_ready), 32'd1);
         end
         data        = use_fixed ? fixed : DW'($urandom);
         write_valid = 1'b1; write_data = data; write_strb = strb;
         chk("wr_ready", 32'(write_ready), 32'd1);
         d.push_back(data);
         @(negedge clk);
         write_valid = 1'b0;
      end
      chk("wr_done_req_ready", 32'(req_ready), 32'd1);
      chk("wr_done_write_ready", 32'(write_ready), 32'd0);
      chk("wr_strobe_count", 32'(strobe_n - start), 32'(n));
      for (int i = 0; i < n && start + i < strobe_n; i++) begin
         chk("wr_strobe_we", 32'(log_we[start+i]), 32'd1);
         chk("wr_strobe_addr", 32'(log_addr[start+i]), 32'((w + i) % DEPTH));
         chk("wr_strobe_be", 32'(log_be[start+i]), 32'(be_exp));
         chk("wr_strobe_data", 32'(log_wd[start+i]), 32'(d[i]));
      end
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < NB; k++) begin
            if (be_exp[k]) ref_mem[(w + i) % DEPTH][k*8 +: 8] = d[i][k*8 +: 8];
         end
      end
   endtask

   task automatic do_read(input logic [AW-1:0] addr, input bit burst, input logic [13:0] beats,
                          input int stall_beat, input int stall_len, input bit no_wait);
      int            n;
      int            w;
      int            start;
      int            cnt;
      logic [DW-1:0] exp;
      n     = eff_len(burst, beats);
      w     = word_of(addr);
      start = strobe_n;
      if (!no_wait) @(negedge clk);
      chk("rd_req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = addr; req_burst = burst; req_beats = beats;
      read_ready = 1'b1;
      for (int b = 0; b < n; b++) begin
         cnt = 0;
         do begin
            @(negedge clk);
            req_valid = 1'b0;
            cnt++;
         end while (read_valid !== 1'b1 && cnt < 20);
         chk("rd_latency", 32'(cnt), 32'd3);
         exp = ref_mem[(w + b) % DEPTH];
         chk("rd_data", 32'(read_data), 32'(exp));
         if (b == stall_beat) begin
            read_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               @(negedge clk);
               chk("rd_stall_valid", 32'(read_valid), 32'd1);
               chk("rd_stall_data", 32'(read_data), 32'(exp));
            end
            read_ready = 1'b1;
         end
      end
      @(negedge clk);
      chk("rd_done_req_ready", 32'(req_ready), 32'd1);
      chk("rd_done_valid", 32'(read_valid), 32'd0);
      chk("rd_strobe_count", 32'(strobe_n - start), 32'(n));
      for (int i = 0; i < n && start + i < strobe_n; i++) begin
         chk("rd_strobe_we", 32'(log_we[start+i]), 32'd0);
         chk("rd_strobe_addr", 32'(log_addr[start+i]), 32'((w + i) % DEPTH));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] a;
      bit            bu;
      logic [13:0]   bt;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      int            start;

      rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_burst = 1'b0;
      req_beats = 14'd0; write_valid = 1'b0; write_data = '0; write_strb = '0; read_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_write_ready", 32'(write_ready), 32'd0);
      chk("rst_read_valid", 32'(read_valid), 32'd0);
      chk("rst_read_data", 32'(read_data), 32'd0);
      chk("rst_sram_ce", 32'(sram_ce), 32'd0);
      chk("rst_sram_we", 32'(sram_we), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      chk("rel_req_ready", 32'(req_ready), 32'd1);

      // Fill the whole SRAM so the shadow memory is fully known.
      do_write(BASE, 1'b1, 14'(DEPTH), 2'b11, 0, 1'b0, 16'h0000);

      // Single write of 0xBEEF with the low byte only, word 1.
      do_write(BASE + 32'd2, 1'b0, 14'd0, 2'b01, 0, 1'b1, 16'hBEEF);
      // Four-beat burst at word 0 with write_valid gaps.
      do_write(BASE, 1'b1, 14'd4, 2'b01, 3, 1'b0, 16'h0000);
      // Three-beat burst read, beat 2 stalled for 5 cycles.
      do_read(BASE, 1'b1, 14'd3, 1, 5, 1'b0);
      // Two-beat burst read starting at the last word wraps to word 0.
      do_read(BASE + 32'((DEPTH - 1) * NB), 1'b1, 14'd2, -1, 0, 1'b0);
      // Non-burst request ignores req_beats.
      do_read(BASE + 32'd4, 1'b0, 14'd5, -1, 0, 1'b0);

`ifdef MAM_SRAM_RANGE_CHECK_EN
      // Read below the window: zero data, no strobe, sticky err.
      start = strobe_n;
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = BASE - 32'd2; req_burst = 1'b0; req_beats = 14'd1;
      read_ready = 1'b1;
      repeat (3) begin @(negedge clk); req_valid = 1'b0; end
      chk("oor_valid", 32'(read_valid), 32'd1);
      chk("oor_data", 32'(read_data), 32'd0);
      @(negedge clk);
      chk("oor_strobes", 32'(strobe_n - start), 32'd0);
      chk("oor_err", 32'(err), 32'd1);
      repeat (4) @(negedge clk);
      chk("oor_err_sticky", 32'(err), 32'd1);
`else
      // Below the window the address is truncated onto the last word.
      do_read(BASE - 32'd2, 1'b0, 14'd1, -1, 0, 1'b0);
      chk("trunc_err", 32'(err), 32'd0);
`endif

      for (int t = 0; t < 24; t++) begin
         a  = BASE + 32'($urandom_range(DEPTH - 1, 0)) * 32'(NB) + 32'($urandom_range(NB - 1, 0));
         bu = 1'($urandom_range(1, 0));
         bt = 14'($urandom_range(5, 0));
         if ($urandom_range(1, 0) == 1) begin
            do_write(a, bu, bt, 2'($urandom_range(3, 0)), 2, 1'b0, 16'h0000);
         end else begin
            do_read(a, bu, bt, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'b0);
         end
      end

      // Reset during beat 2 of a 4-beat write at word 8.
      start = strobe_n;
      d0 = DW'($urandom);
      d1 = ~d0;
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b1; req_addr = BASE + 32'd16; req_burst = 1'b1; req_beats = 14'd4;
      @(negedge clk);
      req_valid = 1'b0; write_valid = 1'b1; write_data = d0; write_strb = 2'b11;
      @(negedge clk);
      write_data = d1;
      chk("rst_mid_pre_ce", 32'(sram_ce), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_mid_ce_now", 32'(sram_ce), 32'd0);
      chk("rst_mid_write_ready", 32'(write_ready), 32'd0);
      @(negedge clk);
      chk("rst_mid_ce_hold", 32'(sram_ce), 32'd0);
      write_valid = 1'b0;
      rst = 1'b0;
      chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
      chk("rst_mid_read_valid", 32'(read_valid), 32'd0);
      chk("rst_mid_read_data", 32'(read_data), 32'd0);
      chk("rst_mid_err", 32'(err), 32'd0);
      chk("rst_mid_strobes", 32'(strobe_n - start), 32'd1);
      ref_mem[8] = d0;
      // Request in the very first cycle after release; word 9 must be untouched.
      do_read(BASE + 32'd16, 1'b1, 14'd2, -1, 0, 1'b1);
      // Word 1 still carries the merged single-byte write.
      do_read(BASE + 32'd2, 1'b0, 14'd1, -1, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mam_sram_responder.md
MAM_SRAM_RESPONDER -- requirements
Module: mam_sram_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data word width in bits; a multiple of 16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of requests.
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 10, SRAM word-address width.
REQ-004 SHALL have parameter BASE_ADDR, default 0, byte base address of the SRAM.
REQ-005 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset); one clock domain, reset asynchronous and active-high.
REQ-006 SHALL have the request port: req_valid in 1; req_ready out 1; req_rw in 1 (0 read, 1 write); req_addr in ADDR_WIDTH; req_burst in 1; req_beats in 14.
REQ-007 SHALL have the write data port: write_valid in 1; write_data in DATA_WIDTH; write_strb in DATA_WIDTH/8; write_ready out 1.
REQ-008 SHALL have the read data port: read_valid out 1; read_data out DATA_WIDTH; read_ready in 1.
REQ-009 SHALL have the SRAM port: sram_ce out 1; sram_we out 1; sram_addr out MEM_ADDR_WIDTH; sram_wdata out DATA_WIDTH; sram_be out DATA_WIDTH/8; sram_rdata in DATA_WIDTH, valid the cycle after a read strobe.
REQ-010 SHALL have output err, 1 bit, sticky range-error flag.

Function
REQ-011 SHALL use a state machine with states IDLE, WRITE, READ_ISSUE, READ_WAIT and READ_DATA.
REQ-012 SHALL assert req_ready only in IDLE; a request is accepted on req_valid&&req_ready.
REQ-013 SHALL capture on accept: rw, burst, beats (req_beats==0 treated as 1; non-burst forced to 1), word address = (req_addr-BASE_ADDR)>>log2(DATA_WIDTH/8), truncated to MEM_ADDR_WIDTH.
REQ-014 SHALL go IDLE->WRITE on an accepted write, and IDLE->READ_ISSUE on an accepted read.
REQ-015 WRITE: write_ready=1; on write_valid, same cycle sram_ce=1, sram_we=1, sram_addr=current word, sram_wdata=write_data, sram_be=write_strb if single beat else all ones.
REQ-016 After each write beat: beats decrements and address increments; beats==1 -> IDLE.
REQ-017 READ_ISSUE: sram_ce=1, sram_we=0, go to READ_WAIT; READ_WAIT: register sram_rdata into read_data, go to READ_DATA.
REQ-018 READ_DATA: read_valid=1 with read_data held stable until read_ready.
REQ-019 On the READ_DATA handshake: beats==1 -> IDLE; else beats decrements, address increments, -> READ_ISSUE.
REQ-020 First read_valid SHALL be 3 cycles after request accept; subsequent beats every 3 cycles with read_ready held high.
REQ-021 Burst address increment SHALL wrap modulo 2^MEM_ADDR_WIDTH without error.
REQ-022 sram_ce SHALL be 0 in every state and cycle not listed in REQ-015/REQ-017; write_ready is 0 outside WRITE; read_valid is 0 outside READ_DATA.

Reset
REQ-023 On rst: state=IDLE; req_ready=1 after release; write_ready=0, read_valid=0, read_data=0, sram_ce=0, sram_we=0, err=0, beat counter=0.
REQ-024 Reset mid-burst SHALL abort the transfer immediately with no further SRAM strobes; the first cycle after release accepts a new request.

Configuration
REQ-025 SHALL support macro MAM_SRAM_RANGE_CHECK_EN.
REQ-026 With MAM_SRAM_RANGE_CHECK_EN defined: a beat whose byte address is outside [BASE_ADDR, BASE_ADDR+2^MEM_ADDR_WIDTH*DATA_WIDTH/8) suppresses sram_ce, returns read_data=0 for reads, completes its handshake normally, and sets err until reset.
REQ-027 Without MAM_SRAM_RANGE_CHECK_EN: err tied 0; addresses are truncated per REQ-013.

Verification
REQ-028 Single write 0xBEEF at BASE_ADDR+2, strb 2'b01 -> one sram_ce/we cycle, sram_addr=1, sram_be=2'b01, then IDLE.
REQ-029 Burst write 4 beats at word 0 -> sram_addr 0,1,2,3, be all ones; write_valid gaps produce no extra strobes.
REQ-030 Burst read 3 beats with read_ready low 5 cycles on beat 2 -> read_data stable while stalled, order matches SRAM contents, return to IDLE.
REQ-031 Burst read 2 beats at word 2^MEM_ADDR_WIDTH-1 -> second beat reads word 0.
REQ-032 rst asserted during beat 2 of a 4-beat write -> sram_ce=0 immediately, req_ready=1 after release.
REQ-033 With MAM_SRAM_RANGE_CHECK_EN, read at BASE_ADDR-2 -> read_data=0, no sram_ce, err=1 until reset.
